gtgen: RTL and testbench
========================

GTGEN -- requirements
Module: gtgen

Interface
REQ-001 Parameter CNT_WIDTH, default 22: width of the global time counter (gtout).
REQ-002 Parameter MISS_MAX, default 2: consecutive missed sync periods before lock is dropped.
REQ-003 Parameter ERR_WIDTH, default 8: width of the saturating sync error counter.
REQ-004 extclk  input  1  external 125 MHz clock; the only clock, all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 gtsync  input  1  one-cycle sync pulse from the master, synchronous to extclk, marking counter epoch zero.
REQ-007 raw  input  6  oversampled trigger phase, thermometer code, already registered in extclk domain.
REQ-008 gtout  output  CNT_WIDTH  free-running global time counter, the counter input for timestamp latches.
REQ-009 phase  output  3  encoded phase of raw.
REQ-010 wrap  output  1  one-cycle pulse on the cycle gtout == all ones.
REQ-011 locked  output  1  high while the counter is aligned to the master sync.
REQ-012 errcnt  output  ERR_WIDTH  count of misaligned sync pulses, saturating.

Function
REQ-013 States: UNSYNC, RUN, HOLDOVER; state register 2 bits.
REQ-014 UNSYNC: gtout held 0, locked 0, wrap 0; gtsync -> gtout = 1 next cycle (the sync cycle is epoch 0), go RUN.
REQ-015 RUN and HOLDOVER: gtout increments by 1 every cycle, modulo 2^CNT_WIDTH, all-ones -> 0.
REQ-016 Sync is aligned when gtsync is high on a cycle where gtout == all ones; aligned sync changes no count value.
REQ-017 Misaligned sync in RUN or HOLDOVER: gtout = 0 next cycle, errcnt +1 (saturates at all ones), missed count cleared, state RUN.
REQ-018 Aligned sync in RUN: missed count cleared. Aligned sync in HOLDOVER: missed count cleared, state RUN.
REQ-019 Wrap cycle without gtsync in RUN: missed count +1; on reaching MISS_MAX, state HOLDOVER, counting continues.
REQ-020 In HOLDOVER the missed count stops changing; the counter keeps running.
REQ-021 locked = 1 exactly in RUN, registered, changes on the cycle after the state transition.
REQ-022 wrap is combinationally decoded from the registered gtout, so it is high in the same cycle gtout == all ones; wrap is 0 in UNSYNC.
REQ-023 Phase encoder: phase = number of ones in raw (0..6), registered, latency 1 cycle.
REQ-024 Bubbled (non-thermometer) raw is encoded by popcount, with no error flag.
REQ-025 phase is independent of the state machine and valid in all states.
REQ-026 gtsync on the same cycle as reset is ignored.

Reset
REQ-027 On reset: state UNSYNC, gtout 0, locked 0, errcnt 0, missed count 0, phase 0.
REQ-028 Reset asserted mid-count returns the block to UNSYNC the next cycle.
REQ-029 After reset, only a new gtsync restarts counting.

Structure
REQ-030 Shared package gt_pkg holds the state encoding and the CNT_WIDTH default of 22, also used by gtout consumers.
REQ-031 One sub-module, gtphase_enc: 6-bit popcount plus output register.
REQ-032 The counter, state machine and error logic are in gtgen itself.

Verification
REQ-033 reset, then gtsync at cycle 10 -> gtout = 1 at cycle 11, locked = 1 at cycle 12, errcnt = 0.
REQ-034 Locked, gtsync every 2^22 cycles on gtout = 0x3FFFFF -> wrap on each, locked stays 1, errcnt stays 0 over 3 periods.
REQ-035 Locked, gtsync at gtout = 0x001234 -> gtout = 0 next cycle, errcnt = 1, locked stays 1.
REQ-036 Locked, syncs stop -> locked = 0 after the 2nd wrap, gtout keeps counting; next aligned sync -> locked = 1.
REQ-037 raw = 6'b000111 -> phase = 3 one cycle later; raw = 6'b111111 -> 6; raw = 6'b010100 -> 2.
REQ-038 errcnt preset to 255 via 255 misaligned syncs, then one more -> errcnt stays 255; reset mid-count -> gtout = 0, state UNSYNC.

Source files
------------

// File: rtl/gt_pkg.sv
// Global time generator shared types.
// Also imported by timestamp latches that consume gtout.
package gt_pkg;

    localparam int GT_CNT_WIDTH = 22;

    typedef enum logic [1:0] {
        UNSYNC   = 2'b00,
        RUN      = 2'b01,
        HOLDOVER = 2'b10
    } gt_state_e;

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < 6; i++) begin
            s = s + {2'b00, v[i]};
        end
        return s;
    endfunction

endpackage

// File: rtl/gtgen_phase.sv
// Trigger phase encoder.
// Popcount of the oversampled thermometer code, one register stage.
module gtphase_enc
    import gt_pkg::*;
(
    input  logic       extclk,
    input  logic       reset,
    input  logic [5:0] raw,
    output logic [2:0] phase
);

    always_ff @(posedge extclk) begin
        if (reset) begin
            phase <= '0;
        end else begin
            phase <= popcount6(raw);
        end
    end

endmodule

// File: rtl/gtgen.sv
// Global time counter aligned to the master sync pulse.
// Tracks lock, missed sync periods and misaligned syncs.
module gtgen
    import gt_pkg::*;
#(
    parameter int CNT_WIDTH = GT_CNT_WIDTH,
    parameter int MISS_MAX  = 2,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 extclk,
    input  logic                 reset,
    input  logic                 gtsync,
    input  logic [5:0]           raw,
    output logic [CNT_WIDTH-1:0] gtout,
    output logic [2:0]           phase,
    output logic                 wrap,
    output logic                 locked,
    output logic [ERR_WIDTH-1:0] errcnt
);

    localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    gt_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [ERR_WIDTH-1:0] err_d;
    logic [MW-1:0]        miss_q, miss_d, miss_inc;
    logic                 at_top;

    assign at_top   = &gtout;
    assign wrap     = at_top && (state_q != UNSYNC);
    assign miss_inc = miss_q + MW'(1);

    always_ff @(posedge extclk) begin
        if (reset) begin
            state_q <= UNSYNC;
            gtout   <= '0;
            errcnt  <= '0;
            miss_q  <= '0;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            gtout   <= cnt_d;
            errcnt  <= err_d;
            miss_q  <= miss_d;
            locked  <= (state_q == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = gtout + CNT_WIDTH'(1);
        err_d   = errcnt;
        miss_d  = miss_q;
        unique case (state_q)
            UNSYNC: begin
                cnt_d = '0;
                if (gtsync) begin
                    cnt_d   = CNT_WIDTH'(1);
                    miss_d  = '0;
                    state_d = RUN;
                end
            end
            RUN, HOLDOVER: begin
                if (gtsync && !at_top) begin
                    // Re-anchor epoch zero to the master's pulse
                    cnt_d   = '0;
                    err_d   = (&errcnt) ? errcnt : errcnt + ERR_WIDTH'(1);
                    miss_d  = '0;
                    state_d = RUN;
                end else if (gtsync) begin
                    miss_d  = '0;
                    state_d = RUN;
                end else if (at_top && state_q == RUN) begin
                    miss_d = miss_inc;
                    if (miss_inc == MW'(MISS_MAX)) begin
                        state_d = HOLDOVER;
                    end
                end
            end
            default: begin
                state_d = UNSYNC;
                cnt_d   = '0;
            end
        endcase
    end

    gtphase_enc u_phase (
        .extclk (extclk),
        .reset  (reset),
        .raw    (raw),
        .phase  (phase)
    );

endmodule

// File: tb/tb_gtgen.sv
// Bench for gtgen with a narrow counter so several sync periods fit.
// Reference model plus directed literal checkpoints.
module tb_gtgen;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;
    localparam int MISS = 2;

    logic         extclk = 1'b0;
    logic         reset  = 1'b1;
    logic         gtsync = 1'b0;
    logic [5:0]   raw    = '0;
    logic [W-1:0] gtout;
    logic [2:0]   phase;
    logic         wrap;
    logic         locked;
    logic [7:0]   errcnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int m_cnt   = 0;
    int m_err   = 0;
    int m_miss  = 0;
    int m_phase = 0;
    bit m_run   = 0;
    bit m_hold  = 0;
    bit m_lock  = 0;

    gtgen #(
        .CNT_WIDTH (W),
        .MISS_MAX  (MISS),
        .ERR_WIDTH (8)
    ) dut (
        .extclk (extclk),
        .reset  (reset),
        .gtsync (gtsync),
        .raw    (raw),
        .gtout  (gtout),
        .phase  (phase),
        .wrap   (wrap),
        .locked (locked),
        .errcnt (errcnt)
    );

    always #4 extclk = ~extclk;

    task automatic chk(string name, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: lock is "running and not in holdover" one cycle late
    always @(posedge extclk) begin
        bit top;
        if (reset) begin
            m_run = 0; m_hold = 0; m_cnt = 0;
            m_miss = 0; m_err = 0; m_lock = 0; m_phase = 0;
        end else begin
            m_phase = $countones(raw);
            m_lock  = m_run && !m_hold;
            top     = (m_cnt == MAXV);
            if (!m_run) begin
                if (gtsync) begin
                    m_run = 1; m_cnt = 1; m_miss = 0;
                end
            end else if (gtsync) begin
                if (!top && m_err < 255) m_err = m_err + 1;
                m_cnt = 0; m_miss = 0; m_hold = 0;
            end else begin
                if (top && !m_hold) begin
                    m_miss = m_miss + 1;
                    if (m_miss >= MISS) m_hold = 1;
                end
                m_cnt = (m_cnt + 1) % (MAXV + 1);
            end
        end
    end

    always @(negedge extclk) begin
        if (chk_en) begin
            chk("gtout",  int'(gtout),  m_cnt);
            chk("wrap",   int'(wrap),   int'(m_run && m_cnt == MAXV));
            chk("locked", int'(locked), int'(m_lock));
            chk("errcnt", int'(errcnt), m_err);
            chk("phase",  int'(phase),  m_phase);
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge extclk);
    endtask

    task automatic wait_cnt(int v);
        int k = 0;
        while (m_cnt != v && k < 600) begin
            step();
            k++;
        end
        if (m_cnt != v) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_cnt: count %0d not reached", v);
        end
    endtask

    task automatic pulse_sync();
        gtsync = 1'b1;
        step();
        gtsync = 1'b0;
    endtask

    logic [5:0] raw_tab [5] = '{6'b000111, 6'b111111, 6'b010100,
                                6'b000000, 6'b101010};
    int         ph_tab  [5] = '{3, 6, 2, 0, 3};

    initial begin
        step(3);
        chk_en = 1'b1;
        chk("rst_gtout",  int'(gtout),  0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_errcnt", int'(errcnt), 0);
        chk("rst_phase",  int'(phase),  0);
        reset = 1'b0;
        step(5);
        chk("unsync_hold", int'(gtout), 0);
        chk("unsync_wrap", int'(wrap),  0);

        pulse_sync();
        chk("first_cnt",  int'(gtout),  1);
        chk("first_lock", int'(locked), 0);
        step();
        chk("lock_up",    int'(locked), 1);
        chk("lock_err",   int'(errcnt), 0);

        for (int i = 0; i < 3; i++) begin
            wait_cnt(MAXV);
            chk("aligned_wrap", int'(wrap), 1);
            pulse_sync();
            chk("aligned_cnt",  int'(gtout),  0);
            chk("aligned_lock", int'(locked), 1);
            chk("aligned_err",  int'(errcnt), 0);
        end

        wait_cnt(8'h34);
        pulse_sync();
        chk("mis_cnt",  int'(gtout),  0);
        chk("mis_err",  int'(errcnt), 1);
        chk("mis_lock", int'(locked), 1);

        wait_cnt(MAXV);
        step();
        wait_cnt(MAXV);
        chk("miss2_wrap", int'(wrap), 1);
        step();
        chk("hold_lag",   int'(locked), 1);
        step();
        chk("hold_lock",  int'(locked), 0);
        chk("hold_cnt1",  int'(gtout),  1);
        step();
        chk("hold_cnt2",  int'(gtout),  2);
        wait_cnt(MAXV);
        pulse_sync();
        chk("relock_lag", int'(locked), 0);
        step();
        chk("relock",     int'(locked), 1);
        chk("relock_err", int'(errcnt), 1);

        for (int i = 0; i < 5; i++) begin
            raw = raw_tab[i];
            step();
            chk("phase_vec", int'(phase), ph_tab[i]);
        end

        for (int i = 0; i < 254; i++) begin
            pulse_sync();
            step();
        end
        chk("err_sat", int'(errcnt), 255);
        pulse_sync();
        chk("err_hold", int'(errcnt), 255);
        chk("sat_cnt",  int'(gtout),  0);

        wait_cnt(100);
        reset  = 1'b1;
        gtsync = 1'b1;
        step();
        reset  = 1'b0;
        gtsync = 1'b0;
        chk("mid_rst_cnt",  int'(gtout),  0);
        chk("mid_rst_lock", int'(locked), 0);
        chk("mid_rst_err",  int'(errcnt), 0);
        chk("mid_rst_ph",   int'(phase),  0);
        step(5);
        chk("post_rst_idle", int'(gtout), 0);
        pulse_sync();
        chk("restart_cnt", int'(gtout), 1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
